// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair.
package fib_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      SYNC1 = 2'd1,
      LOCK  = 2'd2
   } fib_state_e;

   localparam int FIB_LAST_IDX  = 12;
   localparam int FIB_WIDTH     = 8;
   localparam int FIB_LAST_TERM = 144;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // count up on inc, stick at the maximum value
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/fib_checker.sv
// Locks onto the wrapping Fibonacci stream and reports match/mismatch/wrap.
// Optional sticky error flag: define FIB_CHK_STICKY_EN.
module fib_checker
   import fib_pkg::*;
#(
   parameter int WIDTH     = FIB_WIDTH,
   parameter int LAST_TERM = FIB_LAST_TERM,
   parameter int IDX_W     = $clog2(FIB_LAST_IDX + 1),
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             match,
   output logic             mismatch,
   output logic             wrap,
   output logic [IDX_W-1:0] term_idx,
   output logic [ERR_W-1:0] err_count,
   output logic             err_sticky
);

   localparam logic [WIDTH-1:0] LAST_V  = LAST_TERM[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   fib_state_e       state_r, state_s;
   logic [WIDTH-1:0] prev_r, prev2_r, prev_s, prev2_s;
   logic [IDX_W-1:0] idx_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] exp_s;
   logic             exp_ok_s, match_s, mismatch_s, wrap_s;

   // expected next term; prev==0 in LOCK only occurs right after the wrap
   always_comb begin
      sum_s = {1'b0, prev_r} + {1'b0, prev2_r};
      if (prev_r == LAST_V) begin
         exp_s    = '0;
         exp_ok_s = 1'b1;
      end else if (prev_r == '0) begin
         exp_s    = ONE_V;
         exp_ok_s = 1'b1;
      end else begin
         exp_s    = sum_s[WIDTH-1:0];
         exp_ok_s = ~sum_s[WIDTH];
      end
   end

   // next-state and pulse decode for an accepted sample
   always_comb begin
      state_s    = state_r;
      prev_s     = prev_r;
      prev2_s    = prev2_r;
      idx_s      = term_idx;
      match_s    = 1'b0;
      mismatch_s = 1'b0;
      wrap_s     = 1'b0;
      if (in_valid) begin
         case (state_r)
            HUNT: begin
               if (in_data == '0) begin
                  state_s = SYNC1;
                  idx_s   = '0;
                  prev_s  = '0;
               end else begin
                  state_s = HUNT;
               end
            end
            SYNC1: begin
               if (in_data == ONE_V) begin
                  state_s = LOCK;
                  idx_s   = IDX_ONE;
                  prev2_s = '0;
                  prev_s  = ONE_V;
                  match_s = 1'b1;
               end else if (in_data == '0) begin
                  mismatch_s = 1'b1;
                  idx_s      = '0;
                  prev_s     = '0;
               end else begin
                  state_s    = HUNT;
                  mismatch_s = 1'b1;
               end
            end
            LOCK: begin
               if (exp_ok_s && (in_data == exp_s)) begin
                  match_s = 1'b1;
                  wrap_s  = (in_data == LAST_V);
                  prev_s  = in_data;
                  prev2_s = (in_data == '0) ? '0 : prev_r;
                  idx_s   = (in_data == '0) ? '0 : term_idx + IDX_ONE;
               end else if (in_data == '0) begin
                  mismatch_s = 1'b1;
                  state_s    = SYNC1;
                  idx_s      = '0;
                  prev_s     = '0;
               end else begin
                  mismatch_s = 1'b1;
                  state_s    = HUNT;
               end
            end
            default: begin
               state_s = HUNT;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // state, history and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= HUNT;
         prev_r   <= '0;
         prev2_r  <= '0;
         term_idx <= '0;
         locked   <= 1'b0;
         match    <= 1'b0;
         mismatch <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state_r  <= state_s;
         prev_r   <= prev_s;
         prev2_r  <= prev2_s;
         term_idx <= idx_s;
         locked   <= (state_s == LOCK);
         match    <= match_s;
         mismatch <= mismatch_s;
         wrap     <= wrap_s;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (mismatch_s),
      .count (err_count)
   );

`ifdef FIB_CHK_STICKY_EN
   // sticky flag survives counter saturation, only rst clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky <= 1'b0;
      end else if (mismatch_s) begin
         err_sticky <= 1'b1;
      end else begin
         err_sticky <= err_sticky;
      end
   end
`else
   assign err_sticky = 1'b0;
`endif

endmodule
